// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store.
// Data wins collisions until fetch has been passed over STARVE_LIM times.
module mem_port_arbiter #(
   parameter int unsigned AW         = 32,
   parameter int unsigned DW         = 32,
   parameter int unsigned STARVE_LIM = 4,
   parameter int unsigned TIMEOUT    = 15
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          if_req,
   input  logic [AW-1:0] if_addr,
   output logic          if_ack,
   output logic [DW-1:0] if_rdata,
   input  logic          d_req,
   input  logic          d_we,
   input  logic [AW-1:0] d_addr,
   input  logic [DW-1:0] d_wdata,
   output logic          d_ack,
   output logic [DW-1:0] d_rdata,
   output logic          mem_req,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   input  logic          mem_ready,
   output logic          stall,
   output logic          err
);

   localparam int unsigned SW = $clog2(STARVE_LIM + 1);
   localparam int unsigned WW = $clog2(TIMEOUT + 1);

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] BUSY_IF = 2'd1;
   localparam logic [1:0] BUSY_D  = 2'd2;

   logic [1:0]    state_q, state_d;
   logic          mem_req_q, mem_req_d;
   logic          mem_we_q, mem_we_d;
   logic [AW-1:0] mem_addr_q, mem_addr_d;
   logic [DW-1:0] mem_wdata_q, mem_wdata_d;
   logic          if_ack_q, if_ack_d;
   logic          d_ack_q, d_ack_d;
   logic [DW-1:0] if_rdata_q, if_rdata_d;
   logic [DW-1:0] d_rdata_q, d_rdata_d;
   logic          err_q, err_d;
   logic [SW-1:0] starve_q, starve_d;
   logic [WW-1:0] wait_q, wait_d;

   logic          if_elig, d_elig, d_win, starved, done, expired;
   logic [DW-1:0] rd;

   // The ack term keeps a just-completed requester from being re-granted.
   assign if_elig = if_req & ~if_ack_q;
   assign d_elig  = d_req & ~d_ack_q;
   assign starved = (starve_q == SW'(STARVE_LIM));
   assign d_win   = d_elig & ~(if_elig & starved);
   assign expired = (wait_q == WW'(TIMEOUT - 1));
   assign done    = mem_ready | expired;
   assign rd      = mem_ready ? mem_rdata : '0;

   always_comb begin
      state_d     = state_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      if_ack_d    = 1'b0;
      d_ack_d     = 1'b0;
      if_rdata_d  = if_rdata_q;
      d_rdata_d   = d_rdata_q;
      err_d       = err_q;
      starve_d    = starve_q;
      wait_d      = wait_q;
      unique case (state_q)
         IDLE: begin
            if (d_win) begin
               state_d     = BUSY_D;
               mem_req_d   = 1'b1;
               mem_we_d    = d_we;
               mem_addr_d  = d_addr;
               mem_wdata_d = d_wdata;
               wait_d      = '0;
               if (!if_req)
                  starve_d = '0;
               else if (!starved)
                  starve_d = starve_q + 1'b1;
            end else if (if_elig) begin
               state_d     = BUSY_IF;
               mem_req_d   = 1'b1;
               mem_we_d    = 1'b0;
               mem_addr_d  = if_addr;
               mem_wdata_d = '0;
               wait_d      = '0;
               starve_d    = '0;
            end
         end
         BUSY_IF, BUSY_D: begin
            if (done) begin
               state_d   = IDLE;
               mem_req_d = 1'b0;
               mem_we_d  = 1'b0;
               if (!mem_ready)
                  err_d = 1'b1;
               if (state_q == BUSY_IF) begin
                  if_ack_d   = 1'b1;
                  if_rdata_d = rd;
               end else begin
                  d_ack_d   = 1'b1;
                  d_rdata_d = rd;
               end
            end else begin
               wait_d = wait_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         if_ack_q    <= 1'b0;
         d_ack_q     <= 1'b0;
         if_rdata_q  <= '0;
         d_rdata_q   <= '0;
         err_q       <= 1'b0;
         starve_q    <= '0;
         wait_q      <= '0;
      end else begin
         state_q     <= state_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         if_ack_q    <= if_ack_d;
         d_ack_q     <= d_ack_d;
         if_rdata_q  <= if_rdata_d;
         d_rdata_q   <= d_rdata_d;
         err_q       <= err_d;
         starve_q    <= starve_d;
         wait_q      <= wait_d;
      end
   end

   assign mem_req   = mem_req_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign if_ack    = if_ack_q;
   assign d_ack     = d_ack_q;
   assign if_rdata  = if_rdata_q;
   assign d_rdata   = d_rdata_q;
   assign err       = err_q;
   assign stall     = (if_req & ~if_ack_q) | (d_req & ~d_ack_q);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and randomized checks of mem_port_arbiter against a
// cycle-level transaction model.
module tb_mem_port_arbiter;

   localparam int AW  = 32;
   localparam int DW  = 32;
   localparam int LIM = 4;
   localparam int TMO = 15;

   logic          clk, rst_n;
   logic          if_req, d_req, d_we, mem_ready;
   logic [AW-1:0] if_addr, d_addr;
   logic [DW-1:0] d_wdata, mem_rdata;
   logic          if_ack, d_ack, mem_req, mem_we, stall, err;
   logic [DW-1:0] if_rdata, d_rdata, mem_wdata;
   logic [AW-1:0] mem_addr;

   int tests = 0;
   int fails = 0;

   // model: which port owns the memory (0 none, 1 fetch, 2 data)
   int            m_port, m_waited, m_starve;
   logic          m_mreq, m_mwe, m_iack, m_dack, m_err;
   logic          m_dload, m_dchk;
   logic [AW-1:0] m_maddr;
   logic [DW-1:0] m_mwdata, m_ird, m_drd;

   mem_port_arbiter #(
      .AW(AW), .DW(DW), .STARVE_LIM(LIM), .TIMEOUT(TMO)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .if_req(if_req), .if_addr(if_addr),
      .if_ack(if_ack), .if_rdata(if_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr),
      .d_wdata(d_wdata), .d_ack(d_ack), .d_rdata(d_rdata),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .mem_ready(mem_ready), .stall(stall), .err(err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: observed timeout, expected finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
      end
   endtask

   task automatic m_reset();
      m_port = 0; m_waited = 0; m_starve = 0;
      m_mreq = 0; m_mwe = 0; m_iack = 0; m_dack = 0; m_err = 0;
      m_dload = 0; m_dchk = 0;
      m_maddr = '0; m_mwdata = '0; m_ird = '0; m_drd = '0;
   endtask

   task automatic m_edge();
      logic ie, de, old_i, old_d;
      logic [DW-1:0] rd;
      old_i = m_iack;
      old_d = m_dack;
      m_iack = 0;
      m_dack = 0;
      if (m_port == 0) begin
         ie = if_req && !old_i;
         de = d_req && !old_d;
         if (de && !(ie && m_starve == LIM)) begin
            m_port = 2; m_mreq = 1; m_mwe = d_we;
            m_maddr = d_addr; m_mwdata = d_wdata;
            m_dload = !d_we; m_waited = 0;
            if (if_req) m_starve = (m_starve < LIM) ? m_starve + 1 : LIM;
            else m_starve = 0;
         end else if (ie) begin
            m_port = 1; m_mreq = 1; m_mwe = 0;
            m_maddr = if_addr; m_mwdata = '0;
            m_waited = 0; m_starve = 0;
         end
      end else if (mem_ready || m_waited + 1 >= TMO) begin
         rd = mem_ready ? mem_rdata : '0;
         if (!mem_ready) m_err = 1;
         if (m_port == 1) begin
            m_iack = 1; m_ird = rd;
         end else begin
            m_dack = 1; m_drd = rd;
            m_dchk = m_dload || !mem_ready;
         end
         m_port = 0; m_mreq = 0; m_mwe = 0;
      end else begin
         m_waited++;
      end
   endtask

   task automatic check_all();
      chk("mem_req", mem_req, m_mreq);
      chk("mem_we", mem_we, m_mwe);
      if (m_mreq) chk("mem_addr", mem_addr, m_maddr);
      if (m_mreq && m_mwe) chk("mem_wdata", mem_wdata, m_mwdata);
      chk("if_ack", if_ack, m_iack);
      chk("d_ack", d_ack, m_dack);
      if (m_iack) chk("if_rdata", if_rdata, m_ird);
      if (m_dack && m_dchk) chk("d_rdata", d_rdata, m_drd);
      chk("err", err, m_err);
      chk("stall", stall, (if_req && !m_iack) || (d_req && !m_dack));
   endtask

   task automatic step();
      @(posedge clk);
      m_edge();
      @(negedge clk);
      check_all();
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_mem_req"}, mem_req, 0);
      chk({tag, "_mem_we"}, mem_we, 0);
      chk({tag, "_if_ack"}, if_ack, 0);
      chk({tag, "_d_ack"}, d_ack, 0);
      chk({tag, "_err"}, err, 0);
      chk({tag, "_mem_addr"}, mem_addr, 0);
      chk({tag, "_mem_wdata"}, mem_wdata, 0);
      chk({tag, "_if_rdata"}, if_rdata, 0);
      chk({tag, "_d_rdata"}, d_rdata, 0);
   endtask

   initial begin
      rst_n = 0; if_req = 0; d_req = 0; d_we = 0; mem_ready = 0;
      if_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0;
      m_reset();
      #1;
      chk_zero("rst");
      repeat (2) @(negedge clk);

      // single fetch, granted on the first edge after reset release
      rst_n = 1; if_req = 1; if_addr = 32'h100;
      mem_ready = 1; mem_rdata = 32'h0050_0093;
      step();
      chk("f_req", mem_req, 1);
      chk("f_addr", mem_addr, 32'h100);
      step();
      chk("f_ack", if_ack, 1);
      chk("f_rdata", if_rdata, 32'h0050_0093);
      chk("f_req_off", mem_req, 0);
      step();
      chk("f_no_regrant", mem_req, 0);
      if_req = 0;
      step();

      // collision: store first, then fetch
      if_req = 1; if_addr = 32'h200;
      d_req = 1; d_we = 1; d_addr = 32'h20; d_wdata = 32'hDEAD_BEEF;
      mem_rdata = 32'h1111_2222;
      step();
      chk("c_we", mem_we, 1);
      chk("c_addr", mem_addr, 32'h20);
      chk("c_wdata", mem_wdata, 32'hDEAD_BEEF);
      step();
      chk("c_dack", d_ack, 1);
      d_req = 0; d_we = 0;
      step();
      chk("c_f_addr", mem_addr, 32'h200);
      chk("c_f_we", mem_we, 0);
      step();
      chk("c_iack", if_ack, 1);
      if_req = 0;
      step();

      // three wait states on a load
      d_req = 1; d_we = 0; d_addr = 32'h44; mem_ready = 0;
      mem_rdata = 32'h1234_5678;
      for (int i = 0; i < 4; i++) begin
         step();
         chk("w_req", mem_req, 1);
         chk("w_addr", mem_addr, 32'h44);
         chk("w_stall", stall, 1);
      end
      mem_ready = 1;
      step();
      chk("w_ack", d_ack, 1);
      chk("w_rdata", d_rdata, 32'h1234_5678);
      d_req = 0;
      step();

      // timeout on a fetch
      if_req = 1; if_addr = 32'h40; mem_ready = 0;
      step();
      for (int i = 1; i < TMO; i++) begin
         step();
         chk("t_hold", mem_req, 1);
      end
      step();
      chk("t_ack", if_ack, 1);
      chk("t_rdata", if_rdata, 0);
      chk("t_err", err, 1);
      if_req = 0; d_req = 1; d_addr = 32'h80;
      mem_ready = 1; mem_rdata = 32'hCAFE_0001;
      step();
      step();
      chk("t_next_ack", d_ack, 1);
      chk("t_next_rdata", d_rdata, 32'hCAFE_0001);
      chk("t_err_sticky", err, 1);
      d_req = 0;
      step();

      // reset in the middle of a data access
      d_req = 1; d_we = 1; d_addr = 32'h90; d_wdata = 32'h55AA;
      mem_ready = 0;
      step();
      chk("r_busy", mem_req, 1);
      rst_n = 0;
      #1;
      m_reset();
      chk_zero("r_mid");
      @(posedge clk);
      #1;
      chk("r_no_ack", d_ack, 0);
      @(negedge clk);
      d_req = 0; d_we = 0; if_req = 1; if_addr = 32'h300;
      rst_n = 1;
      step();
      chk("r_grant", mem_req, 1);
      chk("r_addr", mem_addr, 32'h300);
      mem_ready = 1;
      step();
      if_req = 0;
      step();

      // randomized traffic against the model
      for (int c = 0; c < 1500; c++) begin
         if (if_req) begin
            if (m_iack) begin
               if_req = 1'($urandom_range(1));
               if_addr = $urandom;
            end else if ($urandom_range(19) == 0) begin
               if_req = 0;
            end
         end else if ($urandom_range(2) == 0) begin
            if_req = 1;
            if_addr = $urandom;
         end
         if (d_req) begin
            if (m_dack) begin
               d_req = 1'($urandom_range(1));
               d_we = 1'($urandom_range(1));
               d_addr = $urandom;
               d_wdata = $urandom;
            end else if ($urandom_range(19) == 0) begin
               d_req = 0;
            end
         end else if ($urandom_range(2) == 0) begin
            d_req = 1;
            d_we = 1'($urandom_range(1));
            d_addr = $urandom;
            d_wdata = $urandom;
         end
         if (c < 500)
            mem_ready = ($urandom_range(3) != 0);
         else if (c < 1000)
            mem_ready = ($urandom_range(29) == 0);
         else
            mem_ready = 1;
         mem_rdata = $urandom;
         step();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
